pc_output_packer: RTL and testbench

Downstream consumer of the polynomial-check (PC) stage in the SDitH signer. Captures the PC results alpha, beta and v (T 32-bit words each) on the PC completion strobe and streams them, one 32-bit word per handshake, into the signature/hash-input buffer with a running write address. It decouples the PC stage from buffer back-pressure, so the PC stage can be restarted as soon as its outputs are captured.

---
 rtl/pc_output_packer.sv | 106 ++++++++++
 tb/tb_pc_output_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_output_packer.sv
// pc_output_packer: captures the PC-stage alpha/beta/v vectors on the done strobe
// and streams them word by word into the signature buffer with a running address.
module pc_output_packer #(
    parameter string FIELD         = "GF256",
    parameter string PARAMETER_SET = "L1",
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    ADDR_WIDTH    = 10,
    parameter int    BASE_ADDR     = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [32*T-1:0]       i_alpha,
    input  logic [32*T-1:0]       i_beta,
    input  logic [32*T-1:0]       i_v,
    output logic [31:0]           o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NW = 3 * T;
    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] LAST = IW'(NW - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [96*T-1:0]    cap_q, cap_d;
    logic               done_q, done_d;
    logic [31:0]        word;

    // The field selector only documents the configuration; it never touches the datapath.
    logic unused_field;
    assign unused_field = (FIELD == "P251");

    // State, index, captured vectors and done pulse registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
        end
    end

    // Next state: capture on start in IDLE, advance on each accepted word in SEND.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    cap_d   = {i_v, i_beta, i_alpha};
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_ready) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the current word from the captured vector; purely registered sources.
    always_comb begin
        word = '0;
        for (int k = 0; k < NW; k++) begin
            if (idx_q == IW'(k)) begin
                word = cap_q[32*k +: 32];
            end
        end
    end

    assign o_data  = word;
    assign o_addr  = BASE + ADDR_WIDTH'(idx_q);
    assign o_valid = (state_q == SEND);
    assign o_busy  = (state_q == SEND);
    assign o_last  = (state_q == SEND) && (idx_q == LAST);
    assign o_done  = done_q;

endmodule

// File: tb/tb_pc_output_packer.sv
// tb_pc_output_packer: scoreboard bench for pc_output_packer,
// covering the T=3 / BASE 0 and T=4 / BASE 1020 configurations.
module tb_pc_output_packer;

    typedef struct packed {
        logic [31:0] d;
        logic [9:0]  a;
        logic        l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    bit           sel;
    logic [127:0] alpha, beta, vv;

    logic [31:0]  data3, data5;
    logic [9:0]   addr3, addr5;
    logic         valid3, valid5, last3, last5;
    logic         busy3, busy5, done3, done5;

    logic [31:0]  data_s;
    logic [9:0]   addr_s;
    logic         valid_s, last_s, busy_s, done_s;

    exp_t         q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           stalls = 0;

    always #5 clk = ~clk;

    pc_output_packer #(
        .FIELD("GF256"), .PARAMETER_SET("L1"), .ADDR_WIDTH(10), .BASE_ADDR(0)
    ) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel),
        .i_alpha(alpha[95:0]), .i_beta(beta[95:0]), .i_v(vv[95:0]),
        .o_data(data3), .o_addr(addr3), .o_valid(valid3), .i_ready(ready),
        .o_last(last3), .o_busy(busy3), .o_done(done3)
    );

    pc_output_packer #(
        .FIELD("P251"), .PARAMETER_SET("L5"), .ADDR_WIDTH(10), .BASE_ADDR(1020)
    ) dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel),
        .i_alpha(alpha), .i_beta(beta), .i_v(vv),
        .o_data(data5), .o_addr(addr5), .o_valid(valid5), .i_ready(ready),
        .o_last(last5), .o_busy(busy5), .o_done(done5)
    );

    assign data_s  = sel ? data5  : data3;
    assign addr_s  = sel ? addr5  : addr3;
    assign valid_s = sel ? valid5 : valid3;
    assign last_s  = sel ? last5  : last3;
    assign busy_s  = sel ? busy5  : busy3;
    assign done_s  = sel ? done5  : done3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every presented word against the head of the scoreboard; pop on transfer.
    always @(negedge clk) begin
        if (valid_s) begin
            chk("have_word", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                chk("data", 64'(data_s), 64'(q[0].d));
                chk("addr", 64'(addr_s), 64'(q[0].a));
                chk("last", 64'(last_s), 64'(q[0].l));
                if (ready) void'(q.pop_front());
                else stalls++;
            end
        end
    end

    task automatic launch(input logic [31:0] base);
        int t;
        logic [9:0] ba;
        t  = sel ? 4 : 3;
        ba = sel ? 10'd1020 : 10'd0;
        alpha = '0;
        beta  = '0;
        vv    = '0;
        for (int k = 0; k < t; k++) begin
            alpha[32*k +: 32] = base + 32'(k);
            beta[32*k +: 32]  = base + 32'(t + k);
            vv[32*k +: 32]    = base + 32'(2 * t + k);
        end
        for (int i = 0; i < 3 * t; i++) begin
            q.push_back(exp_t'{d: base + 32'(i), a: ba + 10'(i), l: (i == 3 * t - 1)});
        end
        start = 1'b1;
    endtask

    task automatic wait_done(input int mode, input int inj, input int rst_at, input bit chain);
        bit seen;
        int nw;
        nw = sel ? 12 : 9;
        seen = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ready  = 1'b1;
        stalls = 0;
        chk("busy_e0", 64'(busy_s), 64'd1);
        chk("valid_e0", 64'(valid_s), 64'd1);
        chk("done_e0", 64'(done_s), 64'd0);
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            start = (k == inj);
            if (k == inj) begin
                alpha = {4{32'hDEAD_BEEF}};
                beta  = {4{32'hCAFE_F00D}};
                vv    = {4{32'h5555_AAAA}};
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", 64'(valid_s), 64'd0);
                chk("rst_busy", 64'(busy_s), 64'd0);
                chk("rst_last", 64'(last_s), 64'd0);
                q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (done_s) begin
                seen = 1'b1;
                chk("latency", 64'(k), 64'(nw + stalls));
                chk("busy_done", 64'(busy_s), 64'd0);
            end
            ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
        end
        ready = 1'b1;
        chk("done_seen", 64'(seen), 64'd1);
        if (!chain && seen) begin
            @(posedge clk);
            #1;
            chk("done_pulse", 64'(done_s), 64'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        alpha = '0;
        beta  = '0;
        vv    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid3", 64'(valid3), 64'd0);
        chk("rst_busy3", 64'(busy3), 64'd0);
        chk("rst_last3", 64'(last3), 64'd0);
        chk("rst_done3", 64'(done3), 64'd0);
        chk("rst_data3", 64'(data3), 64'd0);
        chk("rst_addr3", 64'(addr3), 64'd0);
        chk("rst_addr5", 64'(addr5), 64'd1020);
        chk("rst_data5", 64'(data5), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        launch(32'd1);
        wait_done(0, -1, -1, 1'b0);

        launch(32'd1);
        wait_done(1, -1, -1, 1'b0);

        launch(32'd1);
        wait_done(0, 4, -1, 1'b0);

        launch(32'd1);
        wait_done(0, -1, 5, 1'b0);
        launch(32'd1);
        wait_done(0, -1, -1, 1'b0);

        launch(32'h100);
        wait_done(0, -1, -1, 1'b1);
        launch(32'h200);
        wait_done(0, -1, -1, 1'b0);

        sel = 1'b1;
        @(posedge clk);
        #1;
        launch(32'd1);
        wait_done(0, -1, -1, 1'b0);
        launch(32'h40);
        wait_done(1, -1, -1, 1'b0);

        chk("q_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
